tlb_maint: RTL and testbench

- Sequencer that executes TLB maintenance instructions (TLBWR, TLBFILL, TLBRD, TLBSRCH, INVTLB) against the 16-entry TLB array.
- Drives the TLB's write, read and one search port.
- Sits between the EX/MEM stage plus CSR file (upstream) and the TLB array (downstream).
- INVTLB is implemented as a per-entry walk. Each matching entry is rewritten with E=0.

---
 rtl/tlb_pkg.sv | 52 +++++
 rtl/tlb_inv_match.sv | 36 +++
 rtl/tlb_maint.sv | 190 +++++++++++++++++++
 tb/tb_tlb_maint.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB definitions: entry layout, maintenance op encodings and FSM states
// used by the maintenance sequencer and its INVTLB match helper.
package tlb_pkg;

  // Packed entry, MSB first: E | VPPN | PS | ASID | G | page0 | page1.
  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  localparam int ENTRY_W = $bits(tlb_entry_t);

  localparam logic [5:0] PS_HUGE = 6'd21;

  typedef enum logic [2:0] {
    OP_TLBSRCH = 3'd0,
    OP_TLBRD   = 3'd1,
    OP_TLBWR   = 3'd2,
    OP_TLBFILL = 3'd3,
    OP_INVTLB  = 3'd4
  } tlb_op_e;

  localparam logic [4:0] INV_ALL      = 5'd0;
  localparam logic [4:0] INV_ALL_ALT  = 5'd1;
  localparam logic [4:0] INV_G1       = 5'd2;
  localparam logic [4:0] INV_G0       = 5'd3;
  localparam logic [4:0] INV_ASID     = 5'd4;
  localparam logic [4:0] INV_ASID_VA  = 5'd5;
  localparam logic [4:0] INV_GASID_VA = 5'd6;
  localparam logic [4:0] INV_LAST     = INV_GASID_VA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WALK = 2'd2,
    ST_DONE = 2'd3
  } tlb_state_e;

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB selector: decides whether one TLB entry is hit by the
// given invalidate op / asid / vppn.
module tlb_inv_match
  import tlb_pkg::*;
(
  input  logic [4:0]         inv_op,
  input  logic [9:0]         asid,
  input  logic [18:0]        vppn,
  input  logic [ENTRY_W-1:0] entry,
  output logic               hit
);

  tlb_entry_t ent;
  logic       asid_eq;
  logic       va_eq;

  assign ent     = tlb_entry_t'(entry);
  assign asid_eq = (ent.asid == asid);
  // Huge pages (ps==21) only compare the upper 9 vppn bits.
  assign va_eq   = (ent.vppn[18:10] == vppn[18:10]) &&
                   ((ent.ps == PS_HUGE) || (ent.vppn[9:0] == vppn[9:0]));

  always_comb begin
    hit = 1'b0;
    case (inv_op)
      INV_ALL, INV_ALL_ALT: hit = ent.e;
      INV_G1:               hit = ent.e & ent.g;
      INV_G0:               hit = ent.e & ~ent.g;
      INV_ASID:             hit = ent.e & ~ent.g & asid_eq;
      INV_ASID_VA:          hit = ent.e & ~ent.g & asid_eq & va_eq;
      INV_GASID_VA:         hit = ent.e & (ent.g | asid_eq) & va_eq;
      default:              hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_maint.sv
// TLB maintenance sequencer: executes TLBSRCH/TLBRD/TLBWR/TLBFILL in one cycle
// and INVTLB as a one-entry-per-cycle walk over the TLB array.
module tlb_maint
  import tlb_pkg::*;
#(
  parameter int  TLBNUM = 16,
  localparam int IDX_W  = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [4:0]         req_inv_op,
  input  logic [9:0]         req_inv_asid,
  input  logic [18:0]        req_inv_vppn,
  input  logic [IDX_W-1:0]   csr_index,
  input  logic [ENTRY_W-1:0] csr_entry,
  input  logic [9:0]         csr_asid,
  input  logic [18:0]        csr_vppn,
  output logic [18:0]        s_vppn,
  output logic [9:0]         s_asid,
  input  logic               s_found,
  input  logic [IDX_W-1:0]   s_index,
  output logic [IDX_W-1:0]   r_index,
  input  logic [ENTRY_W-1:0] r_entry,
  output logic               we,
  output logic [IDX_W-1:0]   w_index,
  output logic [ENTRY_W-1:0] w_entry,
  output logic               resp_valid,
  output logic               resp_ine,
  output logic               resp_found,
  output logic [IDX_W-1:0]   resp_index,
  output logic [ENTRY_W-1:0] resp_entry
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

  tlb_state_e         state_reg, state_next;

  logic [2:0]         op_reg;
  logic [4:0]         inv_op_reg;
  logic [9:0]         inv_asid_reg;
  logic [18:0]        inv_vppn_reg;
  logic [IDX_W-1:0]   index_reg;
  logic [ENTRY_W-1:0] entry_reg;
  logic [9:0]         asid_reg;
  logic [18:0]        vppn_reg;
  logic               ine_reg;
  logic [IDX_W-1:0]   walk_cnt_reg;
  logic [IDX_W-1:0]   fill_cnt_reg;
  logic               found_reg;
  logic [IDX_W-1:0]   sidx_reg;
  logic [ENTRY_W-1:0] rentry_reg;

  logic               accept;
  logic               inv_legal;
  logic               inv_hit;
  tlb_entry_t         cleared;

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign inv_legal = (req_inv_op <= INV_LAST);

  tlb_inv_match u_inv_match (
    .inv_op (inv_op_reg),
    .asid   (inv_asid_reg),
    .vppn   (inv_vppn_reg),
    .entry  (r_entry),
    .hit    (inv_hit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ((req_op == OP_INVTLB) && inv_legal) ? ST_WALK : ST_EXEC;
        end
      end
      ST_EXEC: state_next = ST_DONE;
      ST_WALK: if (walk_cnt_reg == LAST_IDX) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // TLB port drive is decoded from state, so nothing leaks outside EXEC/WALK.
  always_comb begin
    s_vppn  = '0;
    s_asid  = '0;
    r_index = '0;
    we      = 1'b0;
    w_index = '0;
    w_entry = '0;
    cleared = tlb_entry_t'(r_entry);
    cleared.e = 1'b0;
    case (state_reg)
      ST_EXEC: begin
        case (op_reg)
          OP_TLBSRCH: begin
            s_vppn = vppn_reg;
            s_asid = asid_reg;
          end
          OP_TLBRD: r_index = index_reg;
          OP_TLBWR: begin
            we      = 1'b1;
            w_index = index_reg;
            w_entry = entry_reg;
          end
          OP_TLBFILL: begin
            we      = 1'b1;
            w_index = fill_cnt_reg;
            w_entry = entry_reg;
          end
          default: ;
        endcase
      end
      ST_WALK: begin
        r_index = walk_cnt_reg;
        if (inv_hit) begin
          we      = 1'b1;
          w_index = walk_cnt_reg;
          w_entry = ENTRY_W'(cleared);
        end
      end
      default: ;
    endcase
  end

  assign resp_valid = (state_reg == ST_DONE);
  assign resp_ine   = (state_reg == ST_DONE) & ine_reg;
  assign resp_found = found_reg;
  assign resp_index = sidx_reg;
  assign resp_entry = rentry_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_reg       <= '0;
      inv_op_reg   <= '0;
      inv_asid_reg <= '0;
      inv_vppn_reg <= '0;
      index_reg    <= '0;
      entry_reg    <= '0;
      asid_reg     <= '0;
      vppn_reg     <= '0;
      ine_reg      <= 1'b0;
      walk_cnt_reg <= '0;
      fill_cnt_reg <= '0;
      found_reg    <= 1'b0;
      sidx_reg     <= '0;
      rentry_reg   <= '0;
    end else begin
      fill_cnt_reg <= (fill_cnt_reg == LAST_IDX) ? '0 : fill_cnt_reg + 1'b1;
      if (accept) begin
        op_reg       <= req_op;
        inv_op_reg   <= req_inv_op;
        inv_asid_reg <= req_inv_asid;
        inv_vppn_reg <= req_inv_vppn;
        index_reg    <= csr_index;
        entry_reg    <= csr_entry;
        asid_reg     <= csr_asid;
        vppn_reg     <= csr_vppn;
        ine_reg      <= (req_op == OP_INVTLB) && !inv_legal;
        walk_cnt_reg <= '0;
      end
      if (state_reg == ST_WALK) begin
        walk_cnt_reg <= walk_cnt_reg + 1'b1;
      end
      if (state_reg == ST_EXEC) begin
        if (op_reg == OP_TLBSRCH) begin
          found_reg <= s_found;
          sidx_reg  <= s_index;
        end
        if (op_reg == OP_TLBRD) begin
          rentry_reg <= r_entry;
        end
      end
    end
  end

endmodule

// File: tb/tb_tlb_maint.sv
// Self-checking bench for tlb_maint: behavioural TLB array, vector table,
// response scoreboard and hand-written reset-during-walk sequence.
module tb_tlb_maint;
  import tlb_pkg::*;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = 4;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               req_valid, req_ready;
  logic [2:0]         req_op;
  logic [4:0]         req_inv_op;
  logic [9:0]         req_inv_asid;
  logic [18:0]        req_inv_vppn;
  logic [IDX_W-1:0]   csr_index;
  logic [ENTRY_W-1:0] csr_entry;
  logic [9:0]         csr_asid;
  logic [18:0]        csr_vppn;
  logic [18:0]        s_vppn;
  logic [9:0]         s_asid;
  logic               s_found;
  logic [IDX_W-1:0]   s_index;
  logic [IDX_W-1:0]   r_index;
  logic [ENTRY_W-1:0] r_entry;
  logic               we;
  logic [IDX_W-1:0]   w_index;
  logic [ENTRY_W-1:0] w_entry;
  logic               resp_valid, resp_ine, resp_found;
  logic [IDX_W-1:0]   resp_index;
  logic [ENTRY_W-1:0] resp_entry;

  always #5 clk = ~clk;

  tlb_maint #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_vppn(req_inv_vppn),
    .csr_index(csr_index), .csr_entry(csr_entry), .csr_asid(csr_asid), .csr_vppn(csr_vppn),
    .s_vppn(s_vppn), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
    .r_index(r_index), .r_entry(r_entry),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .resp_valid(resp_valid), .resp_ine(resp_ine), .resp_found(resp_found),
    .resp_index(resp_index), .resp_entry(resp_entry)
  );

  // Behavioural TLB array driven by the DUT, plus the bench's expected copy.
  logic [ENTRY_W-1:0] tlb_mem [TLBNUM];
  logic [ENTRY_W-1:0] ref_mem [TLBNUM];
  logic               clr_mem = 1'b1;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < TLBNUM; i++) tlb_mem[i] <= '0;
    end else if (we) begin
      tlb_mem[w_index] <= w_entry;
    end
  end

  assign r_entry = tlb_mem[r_index];

  always_comb begin
    tlb_entry_t t;
    s_found = 1'b0;
    s_index = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      t = tlb_entry_t'(tlb_mem[i]);
      if (!s_found && t.e && (t.g || t.asid == s_asid) &&
          t.vppn[18:10] == s_vppn[18:10] &&
          (t.ps == 6'd21 || t.vppn[9:0] == s_vppn[9:0])) begin
        s_found = 1'b1;
        s_index = IDX_W'(i);
      end
    end
  end

  int fill_model;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) fill_model <= 0;
    else         fill_model <= (fill_model + 1) % TLBNUM;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_mem(input string name);
    int bad = 0;
    for (int i = 0; i < TLBNUM; i++) if (tlb_mem[i] !== ref_mem[i]) bad++;
    chk(name, 128'(bad), 128'(0));
  endtask

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic e, input logic [18:0] vppn,
      input logic [5:0] ps, input logic [9:0] asid, input logic g, input logic [19:0] ppn0);
    tlb_entry_t t = '0;
    t.e = e; t.vppn = vppn; t.ps = ps; t.asid = asid; t.g = g;
    t.ppn0 = ppn0; t.ppn1 = ppn0 ^ 20'hFFFFF; t.v0 = 1'b1; t.d1 = 1'b1; t.plv1 = 2'd3;
    return ENTRY_W'(t);
  endfunction

  function automatic bit ref_match(input logic [ENTRY_W-1:0] raw, input logic [4:0] op,
      input logic [9:0] a, input logic [18:0] va);
    tlb_entry_t t = tlb_entry_t'(raw);
    bit am = (t.asid == a);
    bit vm = (t.vppn[18:10] == va[18:10]) && (t.ps == 6'd21 || t.vppn[9:0] == va[9:0]);
    if (!t.e) return 0;
    if (op <= 5'd1) return 1;
    if (op == 5'd2) return t.g;
    if (op == 5'd3) return !t.g;
    if (op == 5'd4) return !t.g && am;
    if (op == 5'd5) return !t.g && am && vm;
    if (op == 5'd6) return (t.g || am) && vm;
    return 0;
  endfunction

  typedef struct {
    logic [2:0]         op;
    logic [4:0]         inv_op;
    logic [9:0]         inv_asid;
    logic [18:0]        inv_vppn;
    logic [3:0]         index;
    logic [ENTRY_W-1:0] entry;
    logic [9:0]         asid;
    logic [18:0]        vppn;
    int                 exp_lat;
    int                 exp_writes;
    logic               exp_ine;
    logic               exp_found;
    logic [3:0]         exp_sidx;
    bit                 poke;
  } vec_t;

  typedef struct {
    logic               ine;
    logic               found;
    logic [3:0]         sidx;
    logic [ENTRY_W-1:0] rentry;
  } resp_t;

  resp_t              sb_q[$];
  logic               hold_found = 1'b0;
  logic [3:0]         hold_sidx  = '0;
  logic [ENTRY_W-1:0] hold_entry = '0;
  vec_t               vecs[$];

  function automatic vec_t mkv(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] ia,
      input logic [18:0] iv, input logic [3:0] idx, input logic [ENTRY_W-1:0] ent,
      input logic [9:0] a, input logic [18:0] va, input int lat, input int wr,
      input logic ine, input logic fnd, input logic [3:0] sidx, input bit poke);
    vec_t v;
    v.op = op; v.inv_op = iop; v.inv_asid = ia; v.inv_vppn = iv; v.index = idx;
    v.entry = ent; v.asid = a; v.vppn = va; v.exp_lat = lat; v.exp_writes = wr;
    v.exp_ine = ine; v.exp_found = fnd; v.exp_sidx = sidx; v.poke = poke;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    resp_t      e, got_r;
    int         lat = 0, nwr = 0, busy_bad = 0;
    bit         got = 0;
    logic [3:0] fm;
    @(negedge clk);
    chk($sformatf("v%0d ready_idle", id), 128'(req_ready), 128'(1));
    req_valid = 1'b1; req_op = v.op; req_inv_op = v.inv_op; req_inv_asid = v.inv_asid;
    req_inv_vppn = v.inv_vppn; csr_index = v.index; csr_entry = v.entry;
    csr_asid = v.asid; csr_vppn = v.vppn;
    if (v.op == OP_TLBSRCH) begin hold_found = v.exp_found; hold_sidx = v.exp_sidx; end
    if (v.op == OP_TLBRD) hold_entry = ref_mem[v.index];
    e.ine = v.exp_ine; e.found = hold_found; e.sidx = hold_sidx; e.rentry = hold_entry;
    sb_q.push_back(e);
    if (v.op == OP_TLBWR) ref_mem[v.index] = v.entry;
    if (v.op == OP_INVTLB)
      for (int i = 0; i < TLBNUM; i++)
        if (ref_match(ref_mem[i], v.inv_op, v.inv_asid, v.inv_vppn)) ref_mem[i][ENTRY_W-1] = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (req_ready) busy_bad++;
      if (v.poke) begin
        req_valid = (lat == 3);
        req_op = OP_TLBWR; csr_index = 4'd15; csr_entry = mk_entry(1, 19'h7FFFF, 12, 1, 1, 20'h1);
      end
      if (we) begin
        nwr++;
        if (v.op == OP_TLBFILL) begin
          fm = fill_model[3:0];
          chk($sformatf("v%0d fill_index", id), 128'(w_index), 128'(fm));
          ref_mem[fm] = v.entry;
        end
      end
      if (resp_valid) begin
        got = 1;
        if (sb_q.size() == 0) begin
          chk($sformatf("v%0d unexpected_resp", id), 128'(1), 128'(0));
        end else begin
          got_r = sb_q.pop_front();
          chk($sformatf("v%0d resp_ine", id), 128'(resp_ine), 128'(got_r.ine));
          chk($sformatf("v%0d resp_found", id), 128'(resp_found), 128'(got_r.found));
          chk($sformatf("v%0d resp_index", id), 128'(resp_index), 128'(got_r.sidx));
          chk($sformatf("v%0d resp_entry", id), 128'(resp_entry), 128'(got_r.rentry));
        end
      end
    end
    if (!got) begin
      chk($sformatf("v%0d resp_timeout", id), 128'(0), 128'(1));
      void'(sb_q.pop_front());
    end
    chk($sformatf("v%0d latency", id), 128'(lat), 128'(v.exp_lat));
    chk($sformatf("v%0d busy_ready", id), 128'(busy_bad), 128'(0));
    chk($sformatf("v%0d write_count", id), 128'(nwr), 128'(v.exp_writes));
    @(negedge clk);
    chk($sformatf("v%0d resp_pulse", id), 128'(resp_valid), 128'(0));
    chk_mem($sformatf("v%0d tlb_contents", id));
    $display("vec %0d op=%0d inv_op=%0d lat=%0d writes=%0d", id, v.op, v.inv_op, lat, nwr);
  endtask

  initial begin
    logic [ENTRY_W-1:0] ent_a;
    int saw;
    req_valid = 0; req_op = 0; req_inv_op = 0; req_inv_asid = 0; req_inv_vppn = 0;
    csr_index = 0; csr_entry = '0; csr_asid = 0; csr_vppn = 0;
    for (int i = 0; i < TLBNUM; i++) ref_mem[i] = '0;

    ent_a = mk_entry(1, 19'h12345, 12, 3, 0, 20'hABCDE);
    vecs.push_back(mkv(OP_TLBWR,   0, 0, 0, 5, ent_a, 0, 0, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_TLBRD,   0, 0, 0, 5, '0, 0, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_TLBSRCH, 0, 0, 0, 0, '0, 3, 19'h12345, 2, 0, 0, 1, 5, 0));
    vecs.push_back(mkv(OP_TLBSRCH, 0, 0, 0, 0, '0, 4, 19'h12345, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_TLBWR,   0, 0, 0, 0, mk_entry(1, 19'h00100, 12, 7, 0, 20'h1), 0, 0, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_TLBWR,   0, 0, 0, 1, mk_entry(1, 19'h00200, 12, 7, 1, 20'h2), 0, 0, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_TLBWR,   0, 0, 0, 2, mk_entry(1, 19'h00300, 12, 8, 0, 20'h3), 0, 0, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_INVTLB,  4, 7, 0, 0, '0, 0, 0, 17, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_TLBWR,   0, 0, 0, 3, mk_entry(1, 19'h123FF, 21, 5, 1, 20'h4), 0, 0, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_INVTLB,  6, 10'h3FF, 19'h12345, 0, '0, 0, 0, 17, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_TLBWR,   0, 0, 0, 4, mk_entry(1, 19'h123FF, 12, 5, 1, 20'h5), 0, 0, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_INVTLB,  6, 10'h3FF, 19'h12345, 0, '0, 0, 0, 17, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_TLBRD,   0, 0, 0, 3, '0, 0, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_INVTLB,  2, 0, 0, 0, '0, 0, 0, 17, 2, 0, 0, 0, 1));
    vecs.push_back(mkv(OP_INVTLB,  7, 0, 0, 0, '0, 0, 0, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(OP_INVTLB,  5, 3, 19'h12345, 0, '0, 0, 0, 17, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(OP_INVTLB,  31, 0, 0, 0, '0, 0, 0, 2, 0, 1, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mkv(OP_TLBFILL, 0, 0, 0, 0, mk_entry(1, 19'h40000 + 19'(k), 12, 9, 0, 20'(k)),
                         0, 0, 2, 1, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 128'(req_ready), 128'(1));
    chk("reset we", 128'(we), 128'(0));
    chk("reset resp_valid", 128'(resp_valid), 128'(0));
    chk("reset resp_found", 128'(resp_found), 128'(0));
    chk("reset resp_index", 128'(resp_index), 128'(0));
    chk("reset resp_entry", 128'(resp_entry), 128'(0));
    @(negedge clk);
    clr_mem = 1'b0;
    resetn  = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset arriving mid-walk: entries already visited stay cleared.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_INVTLB; req_inv_op = 5'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("walk r_index at cnt 8", 128'(r_index), 128'(8));
    for (int i = 0; i < 8; i++)
      if (ref_match(ref_mem[i], 5'd0, 0, 0)) ref_mem[i][ENTRY_W-1] = 1'b0;
    resetn = 1'b0;
    #1;
    chk("abort we", 128'(we), 128'(0));
    chk("abort req_ready", 128'(req_ready), 128'(1));
    chk("abort resp_valid", 128'(resp_valid), 128'(0));
    saw = 0;
    repeat (3) @(negedge clk) if (resp_valid) saw++;
    resetn = 1'b1;
    hold_found = 1'b0; hold_sidx = '0; hold_entry = '0;
    repeat (20) @(negedge clk) if (resp_valid || we) saw++;
    chk("abort no_resp_no_write", 128'(saw), 128'(0));
    chk_mem("abort tlb_contents");
    $display("reset-during-walk sequence done, spurious events=%0d", saw);

    run_vec(mkv(OP_TLBFILL, 0, 0, 0, 0, mk_entry(1, 19'h55555, 12, 2, 0, 20'h9), 0, 0, 2, 1, 0, 0, 0, 0), 99);
    run_vec(mkv(OP_TLBRD, 0, 0, 0, 0, '0, 0, 0, 2, 0, 0, 0, 0, 0), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
